// File: rtl/floppy_pkg.sv
// Shared definitions for the floppy head-positioning blocks: track geometry,
// step-direction encoding and the seek sequencer state encoding.
package floppy_pkg;

    localparam int TRK_W     = 7;
    localparam int MAX_TRACK = 79;

    localparam logic DIR_IN  = 1'b1;  // toward higher track numbers
    localparam logic DIR_OUT = 1'b0;  // toward track 0

    typedef enum logic [2:0] {
        S_IDLE,
        S_DIR_SETUP,
        S_STEP_HI,
        S_STEP_LO,
        S_CHECK,
        S_SETTLE,
        S_FINISH
    } seek_state_e;

    // Targets beyond the last physical track are pulled back onto it.
    function automatic logic [TRK_W-1:0] clamp_track(input logic [TRK_W-1:0] trk);
        return (trk > TRK_W'(MAX_TRACK)) ? TRK_W'(MAX_TRACK) : trk;
    endfunction

endpackage

// File: rtl/seek_timer.sv
// Shared wait-state down-counter. Loading N makes expire_o pulse in the N-th
// cycle after the load, so a state entered with the load lasts exactly N cycles.
module seek_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] count_i,
    output logic             expire_o
);

    logic [CNT_W-1:0] cnt_q;
    logic             run_q;

    // Count down from the loaded value and stop after reaching zero.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (load_i) begin
            cnt_q <= count_i - 1'b1;
            run_q <= 1'b1;
        end else if (run_q) begin
            if (cnt_q == '0) run_q <= 1'b0;
            else             cnt_q <= cnt_q - 1'b1;
        end
    end

    assign expire_o = run_q && (cnt_q == '0);

endmodule

// File: rtl/head_seek_ctrl.sv
// Seek sequencer feeding the debounced step driver: accepts recalibrate/seek
// commands, emits timed step pulses with a direction level and tracks the
// head position, using the track-0 sensor to (re)establish it.
module head_seek_ctrl
    import floppy_pkg::*;
#(
    parameter int STEP_PULSE_CYC  = 48,
    parameter int STEP_PERIOD_CYC = 36000,
    parameter int DIR_SETUP_CYC   = 12,
    parameter int SETTLE_CYC      = 180000,
    parameter int RECAL_LIMIT     = 85
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_recal,
    input  logic [TRK_W-1:0] cmd_track,
    input  logic             tr0,
    output logic             step,
    output logic             dir,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [TRK_W-1:0] cur_track,
    output logic             track_valid
);

    localparam int MAX_A   = (STEP_PERIOD_CYC > SETTLE_CYC) ? STEP_PERIOD_CYC : SETTLE_CYC;
    localparam int MAX_B   = (STEP_PULSE_CYC > DIR_SETUP_CYC) ? STEP_PULSE_CYC : DIR_SETUP_CYC;
    localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam int RC_W    = $clog2(RECAL_LIMIT + 1);
    // The CHECK cycle between STEP_LO and the next STEP_HI is part of the low
    // time, so STEP_LO is one cycle shorter to keep the rising-edge period exact.
    localparam int STEP_LO_CYC = STEP_PERIOD_CYC - STEP_PULSE_CYC - 1;

    seek_state_e       state_q, state_d;
    logic [TRK_W-1:0]  target_q, target_d;
    logic [TRK_W-1:0]  cur_q, cur_d;
    logic [RC_W-1:0]   rcnt_q, rcnt_d;
    logic              recal_q, recal_d;      // currently hunting for track 0
    logic              pend_q, pend_d;        // a seek follows the recal
    logic              stepped_q, stepped_d;  // a step was issued this command
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic              dir_q, dir_d;
    logic              step_q, step_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ready_q, ready_d;
    logic              tr0_meta_q, tr0_s_q;
    logic              timer_load, timer_exp, issue, issue_dir;
    logic [CNT_W-1:0]  timer_count;

    seek_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (timer_load),
        .count_i  (timer_count),
        .expire_o (timer_exp)
    );

    // Two-flop synchroniser for the asynchronous track-0 sensor.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tr0_meta_q <= 1'b0;
            tr0_s_q    <= 1'b0;
        end else begin
            tr0_meta_q <= tr0;
            tr0_s_q    <= tr0_meta_q;
        end
    end

    // State register, head bookkeeping and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            target_q  <= '0;
            cur_q     <= '0;
            rcnt_q    <= '0;
            recal_q   <= 1'b0;
            pend_q    <= 1'b0;
            stepped_q <= 1'b0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            dir_q     <= DIR_OUT;
            step_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            cur_q     <= cur_d;
            rcnt_q    <= rcnt_d;
            recal_q   <= recal_d;
            pend_q    <= pend_d;
            stepped_q <= stepped_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            dir_q     <= dir_d;
            step_q    <= step_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ready_q   <= ready_d;
        end
    end

    // Next-state logic: command acceptance, recal/seek decisions and step timing.
    // NOTE: every variable gets a default up front so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        cur_d       = cur_q;
        rcnt_d      = rcnt_q;
        recal_d     = recal_q;
        pend_d      = pend_q;
        stepped_d   = stepped_q;
        valid_d     = valid_q;
        err_d       = err_q;
        dir_d       = dir_q;
        timer_load  = 1'b0;
        timer_count = '0;
        issue       = 1'b0;
        issue_dir   = dir_q;

        case (state_q)
            S_IDLE: begin
                if (ready_q && cmd_valid) begin
                    target_d  = clamp_track(cmd_track);
                    err_d     = 1'b0;
                    stepped_d = 1'b0;
                    rcnt_d    = '0;
                    recal_d   = cmd_recal || !valid_q;
                    pend_d    = !cmd_recal;
                    state_d   = S_CHECK;
                end
            end
            S_DIR_SETUP: begin
                if (timer_exp) begin
                    state_d     = S_STEP_HI;
                    timer_load  = 1'b1;
                    timer_count = CNT_W'(STEP_PULSE_CYC);
                end
            end
            S_STEP_HI: begin
                if (timer_exp) begin
                    state_d     = S_STEP_LO;
                    timer_load  = 1'b1;
                    timer_count = CNT_W'(STEP_LO_CYC);
                    if (!recal_q) begin
                        if (dir_q == DIR_IN)  cur_d   = cur_q + 1'b1;
                        else if (cur_q != '0) cur_d   = cur_q - 1'b1;
                        else                  valid_d = 1'b0;
                    end
                end
            end
            S_STEP_LO: begin
                if (timer_exp) state_d = S_CHECK;
            end
            S_CHECK: begin
                if (recal_q) begin
                    if (tr0_s_q) begin
                        cur_d   = '0;
                        valid_d = 1'b1;
                        if (pend_q) begin
                            recal_d = 1'b0;
                        end else begin
                            state_d     = S_SETTLE;
                            timer_load  = 1'b1;
                            timer_count = CNT_W'(SETTLE_CYC);
                        end
                    end else if (rcnt_q == RC_W'(RECAL_LIMIT)) begin
                        err_d   = 1'b1;
                        valid_d = 1'b0;
                        state_d = S_FINISH;
                    end else begin
                        issue     = 1'b1;
                        issue_dir = DIR_OUT;
                        rcnt_d    = rcnt_q + 1'b1;
                    end
                end else if (cur_q == target_q) begin
                    if (stepped_q) begin
                        state_d     = S_SETTLE;
                        timer_load  = 1'b1;
                        timer_count = CNT_W'(SETTLE_CYC);
                    end else begin
                        state_d = S_FINISH;
                    end
                end else if (dir_q == DIR_OUT && tr0_s_q && cur_q != '0) begin
                    cur_d = '0;  // sensor says we are at 0: trust it, decide again next cycle
                end else begin
                    issue     = 1'b1;
                    issue_dir = (target_q > cur_q) ? DIR_IN : DIR_OUT;
                end

                if (issue) begin
                    dir_d      = issue_dir;
                    stepped_d  = 1'b1;
                    timer_load = 1'b1;
                    if (issue_dir != dir_q || !stepped_q) begin
                        state_d     = S_DIR_SETUP;
                        timer_count = CNT_W'(DIR_SETUP_CYC);
                    end else begin
                        state_d     = S_STEP_HI;
                        timer_count = CNT_W'(STEP_PULSE_CYC);
                    end
                end
            end
            S_SETTLE: begin
                if (timer_exp) state_d = S_FINISH;
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output decode from the next state so the outputs come straight from flops.
    always_comb begin
        step_d  = (state_d == S_STEP_HI);
        busy_d  = (state_d != S_IDLE) && (state_d != S_FINISH);
        done_d  = (state_d == S_FINISH);
        ready_d = (state_d == S_IDLE);
    end

    assign cmd_ready   = ready_q;
    assign step        = step_q;
    assign dir         = dir_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign cur_track   = cur_q;
    assign track_valid = valid_q;

endmodule

// File: tb/tb_head_seek_ctrl.sv
// Bench for head_seek_ctrl: a physical head model drives the track-0 sensor,
// a command-level reference model predicts pulses, track and status.
module tb_head_seek_ctrl;

    localparam int PULSE  = 4;
    localparam int PERIOD = 20;
    localparam int DSETUP = 2;
    localparam int SETTLE = 10;
    localparam int RLIM   = 8;
    localparam int MAXT   = 79;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_recal = 1'b0;
    logic [6:0] cmd_track = '0;
    logic       cmd_ready, tr0, step, dir, busy, done, err, track_valid;
    logic [6:0] cur_track;

    int vectors = 0;
    int miscompares = 0;

    // physical head / monitor state (written only by the monitor)
    int  cyc = 0, pulse_cnt = 0, out_cnt = 0, done_cnt = 0;
    int  last_rise = 0, last_done_cyc = 0;
    int  width_bad = 0, spacing_bad = 0, setup_bad = 0;
    int  hi_len = 0, dir_age = 0, phys = 0;
    bit  prev_step = 0, prev_dir = 0, have_rise = 0, last_dir = 0;
    int  fall_tracks[$];

    // head relocation requests from the stimulus
    int  phys_init = 0;
    bit  load_phys = 0;

    // command-level reference model
    int  ref_phys = 0, ref_track = 0;
    bit  ref_valid = 0, ref_err = 0;

    head_seek_ctrl #(
        .STEP_PULSE_CYC (PULSE),
        .STEP_PERIOD_CYC(PERIOD),
        .DIR_SETUP_CYC  (DSETUP),
        .SETTLE_CYC     (SETTLE),
        .RECAL_LIMIT    (RLIM)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_recal  (cmd_recal),
        .cmd_track  (cmd_track),
        .tr0        (tr0),
        .step       (step),
        .dir        (dir),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .cur_track  (cur_track),
        .track_valid(track_valid)
    );

    always #5 clk = ~clk;

    assign tr0 = (phys == 0);

    // Physical head and pulse-shape monitor, sampled on the falling clock edge.
    always @(negedge clk) begin
        cyc++;
        if (load_phys) phys = phys_init;
        if (done) begin
            done_cnt++;
            last_done_cyc = cyc;
        end
        if (!rst_n) begin
            prev_step = 0; hi_len = 0; have_rise = 0; dir_age = 0; prev_dir = 0;
        end else begin
            if (dir !== prev_dir) dir_age = 0;
            else                  dir_age++;
            prev_dir = dir;
            if (!busy) have_rise = 0;
            if (step && !prev_step) begin
                pulse_cnt++;
                if (!dir) out_cnt++;
                if (dir_age < DSETUP) setup_bad++;
                if (have_rise && dir == last_dir && cyc - last_rise != PERIOD) spacing_bad++;
                have_rise = 1; last_rise = cyc; last_dir = dir;
                phys = dir ? phys + 1 : (phys > 0 ? phys - 1 : 0);
            end
            if (step) begin
                hi_len++;
            end else if (prev_step) begin
                if (hi_len != PULSE) width_bad++;
                hi_len = 0;
                fall_tracks.push_back(int'(cur_track));
            end
            prev_step = step;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic load_head(input int pos);
        phys_init = pos;
        load_phys = 1;
        tick();
        load_phys = 0;
        ref_phys  = pos;
        repeat (3) tick();
    endtask

    task automatic send_cmd(input bit recal, input int trk);
        int n = 0;
        while (!cmd_ready && n < 100) begin
            tick();
            n++;
        end
        check("ready_before_cmd", cmd_ready, 1);
        cmd_valid = 1;
        cmd_recal = recal;
        cmd_track = 7'(trk);
        @(posedge clk);
        #1;
        cmd_valid = 0;
    endtask

    // Predict a command from head physics, issue it, wait for done and compare.
    task automatic run_cmd(input bit recal, input int trk, output int cycles);
        int  tgt, exp_pulses, exp_out, p0, o0, d0, n;
        bit  got;
        tgt = (trk > MAXT) ? MAXT : trk;
        exp_pulses = 0;
        exp_out    = 0;
        ref_err    = 0;
        if (recal || !ref_valid) begin
            if (ref_phys <= RLIM) begin
                exp_pulses = ref_phys; exp_out = ref_phys;
                ref_phys = 0; ref_track = 0; ref_valid = 1;
            end else begin
                exp_pulses = RLIM; exp_out = RLIM;
                ref_phys -= RLIM; ref_valid = 0; ref_err = 1;
            end
        end
        if (!recal && ref_valid) begin
            if (tgt >= ref_track) exp_pulses += tgt - ref_track;
            else begin
                exp_pulses += ref_track - tgt;
                exp_out    += ref_track - tgt;
            end
            ref_track = tgt;
            ref_phys  = tgt;
        end

        p0 = pulse_cnt; o0 = out_cnt; d0 = done_cnt;
        send_cmd(recal, trk);
        check("busy_after_accept", busy, 1);
        n = 0; got = 0;
        while (n < 4000 && !got) begin
            tick();
            n++;
            if (done) got = 1;
        end
        cycles = n;
        check("done_seen", got, 1);
        check("busy_at_done", busy, 0);
        check("pulses", pulse_cnt - p0, exp_pulses);
        check("outward_pulses", out_cnt - o0, exp_out);
        check("cur_track", cur_track, ref_valid ? ref_track : cur_track);
        check("track_valid", track_valid, ref_valid);
        check("err", err, ref_err);
        tick();
        check("done_once", done_cnt - d0, 1);
    endtask

    initial begin
        int cyc_taken, f0, p0, n, seed_pos;
        bit recal;

        // reset state and release
        repeat (3) tick();
        check("rst_outputs", {step, dir, busy, done, err, track_valid, cmd_ready, cur_track}, 0);
        rst_n = 1;
        check("ready_low_before_edge", cmd_ready, 0);
        @(posedge clk);
        #1;
        check("ready_after_release", cmd_ready, 1);

        // recal from track 3
        load_head(3);
        run_cmd(1, 0, cyc_taken);
        check("recal_dir_out", dir, 0);
        check("recal_settle_time", last_done_cyc - last_rise, PERIOD + SETTLE);

        // seek 0 -> 5
        f0 = fall_tracks.size();
        run_cmd(0, 5, cyc_taken);
        check("seek_fall_count", fall_tracks.size() - f0, 5);
        for (int i = 0; i < 5; i++)
            if (fall_tracks.size() > f0 + i) check("seek_fall_track", fall_tracks[f0 + i], i + 1);
        check("seek_dir_in", dir, 1);
        check("seek_settle_time", last_done_cyc - last_rise, PERIOD + SETTLE);

        // seek to the current track: no steps, no settle
        run_cmd(0, 5, cyc_taken);
        check("null_seek_fast", cyc_taken <= 3, 1);

        // recal that never sees track 0 inside the limit
        load_head(10);
        run_cmd(1, 0, cyc_taken);
        // next seek recalibrates first (2 outward steps), then 77 inward
        run_cmd(0, 77, cyc_taken);

        // clamp: 100 -> 79
        run_cmd(0, 100, cyc_taken);
        check("clamped_track", cur_track, MAXT);

        // reset in the middle of a step pulse
        p0 = pulse_cnt;
        send_cmd(0, 70);
        n = 0;
        while (pulse_cnt < p0 + 2 && n < 200) begin
            tick();
            n++;
        end
        check("second_pulse_seen", pulse_cnt - p0, 2);
        check("step_high_before_reset", step, 1);
        rst_n = 0;
        #1;
        check("step_drop_async", step, 0);
        check("rst_cur_track", cur_track, 0);
        check("rst_track_valid", track_valid, 0);
        check("rst_busy_err", {busy, err, done, dir}, 0);
        ref_valid = 0; ref_track = 0; ref_err = 0;
        repeat (2) tick();
        rst_n = 1;
        @(posedge clk);
        #1;
        check("ready_after_mid_reset", cmd_ready, 1);

        // randomized command mix against the reference model
        seed_pos = $urandom_range(0, RLIM);
        load_head(seed_pos);
        for (int k = 0; k < 10; k++) begin
            recal = ($urandom_range(0, 3) == 0);
            run_cmd(recal, $urandom_range(0, 127), cyc_taken);
        end

        check("pulse_width_errors", width_bad, 0);
        check("pulse_spacing_errors", spacing_bad, 0);
        check("dir_setup_errors", setup_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/head_seek_ctrl.md
Name: head_seek_ctrl

Overview:
- Seek sequencer directly upstream of the debounced 4-coil step driver.
- Accepts recalibrate/seek-to-track commands from the controller and emits timed step pulses plus a direction level, which drive the driver's step/dir inputs.
- Maintains the current head track and uses the track-0 sensor to recalibrate.

Parameters:
- TRK_W, 7, track number width.
- MAX_TRACK, 79, highest legal track; larger targets are clamped to it.
- STEP_PULSE_CYC, 48, step high time in clk cycles; must exceed the driver debounce window.
- STEP_PERIOD_CYC, 36000, step rising-edge to next rising-edge in cycles; requires > STEP_PULSE_CYC.
- DIR_SETUP_CYC, 12, dir-stable time before the first step.
- SETTLE_CYC, 180000, head settle time after the last step.
- RECAL_LIMIT, 85, maximum outward steps before a recalibrate fails.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; a command is accepted on cmd_valid&&cmd_ready.
- cmd_recal  in  1  1 = recalibrate, 0 = seek.
- cmd_track  in  TRK_W  seek target.
- tr0  in  1  raw track-0 sensor, high at track 0; 2-FF synchronised internally (tr0_s).
- step  out  1  step pulse to the driver, registered.
- dir  out  1  1 = inward (track+1), 0 = outward; registered.
- busy  out  1  high from acceptance until done.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky recal failure; cleared on the next accepted command.
- cur_track  out  TRK_W  current head track.
- track_valid  out  1  cur_track is trustworthy.

Behaviour:
- Reset (async, rst_n=0):
  - step, dir, busy, done, err, cur_track, track_valid are all 0.
  - State is IDLE and the synchroniser is cleared.
  - Reset mid-pulse drops step immediately.
- States: IDLE, DIR_SETUP, STEP_HI, STEP_LO, CHECK, SETTLE, FINISH.
- Accept (IDLE, cmd_valid):
  - Latch target = min(cmd_track, MAX_TRACK).
  - Set busy=1 and clear err.
  - If cmd_recal is set, or track_valid=0, go to recal mode. An implicit recal precedes the seek, and the seek continues after a successful recal.
- CHECK (entered after accept and after every STEP_LO):
  - Recal mode:
    - If tr0_s=1: set cur_track=0 and track_valid=1, then go to SETTLE, or continue to seek mode if a seek is pending.
    - Else, if recal steps == RECAL_LIMIT: set err=1 and track_valid=0, then go to FINISH with no settle.
    - Else: set dir=0 and issue a step.
  - Seek mode:
    - If cur_track == target: go to SETTLE if at least one step was issued this command, else go to FINISH.
    - If dir=0 and tr0_s=1 while cur_track != 0: resync cur_track=0 and re-evaluate the next cycle.
    - Otherwise set dir = (target > cur_track) and issue a step.
- Issuing a step:
  - Go to DIR_SETUP for DIR_SETUP_CYC cycles if dir changed or this is the first step of the command; otherwise go straight to STEP_HI.
  - STEP_HI: step=1 for exactly STEP_PULSE_CYC cycles.
  - STEP_LO: step=0 for STEP_PERIOD_CYC−STEP_PULSE_CYC cycles.
  - On the STEP_HI→STEP_LO transition, cur_track is incremented (dir=1) or decremented (dir=0); recal steps do not touch cur_track.
- SETTLE: wait SETTLE_CYC cycles, then go to FINISH.
- FINISH: done=1 and busy=0 for one cycle, then IDLE (cmd_ready=1 the following cycle).
- cur_track never wraps:
  - Decrement at 0 is suppressed and forces recal on the next command via track_valid=0.
  - Increment at MAX_TRACK is impossible by clamping.
- cmd_valid outside IDLE is ignored and not queued.
- tr0 changes are honoured only in CHECK, with 2-cycle synchroniser latency.

Decomposition:
- Shared package floppy_pkg:
  - TRK_W and MAX_TRACK.
  - DIR_IN=1 and DIR_OUT=0.
  - Seek state encoding.
- One sub-module, seek_timer:
  - Down-counter loaded with a cycle count.
  - Emits a single-cycle expire pulse.
  - Width is $clog2 of the largest timing parameter.
  - All wait states share one instance.

Test Plan (sim params: STEP_PULSE_CYC=4, STEP_PERIOD_CYC=20, DIR_SETUP_CYC=2, SETTLE_CYC=10, RECAL_LIMIT=8):
- Assert then release rst_n mid-run -> all outputs 0 while low; cmd_ready=1 one cycle after release.
- Recal; tr0 model rises after the 3rd step -> exactly 3 pulses, each 4 cycles high at 20-cycle spacing, dir=0, cur_track=0, track_valid=1, done once after settle.
- Seek 0→5 after recal -> dir=1 at least 2 cycles before the first rising step, 5 pulses, cur_track steps 1..5 on each falling edge, done 10 cycles after the last step period ends.
- Seek 5→5 -> no pulses, no settle, done within 3 cycles of acceptance.
- Recal with tr0 held 0 -> exactly 8 pulses, err=1, track_valid=0, done; the next seek first performs a recal.
- Seek cmd_track=100 from 77 -> target clamps to 79, 2 pulses; rst_n pulsed during STEP_HI -> step falls asynchronously, cur_track=0, track_valid=0.
